// File: rtl/autosym_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : autosym_sweep_ctrl
// Description : Sweeps all 2^N inputs of a shared netlist, comparing f(x) with
//               f(x ^ alpha). It reports mismatch and on-set counts.
//               Optional macro AUTOSYM_EARLY_ABORT_EN ends the sweep at the
//               first mismatch.
// Revision    : 1.0 - initial release
// ============================================================================
module autosym_sweep_ctrl #(
    parameter int N        = 8,
    parameter int EVAL_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] alpha,
    output logic [N-1:0] x_out,
    input  logic         y_in,
    output logic         busy,
    output logic         done,
    output logic         is_sym,
    output logic [N:0]   mismatch_cnt,
    output logic [N:0]   onset_cnt
);

    localparam int            WW          = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
    localparam logic [WW-1:0] c_WAIT_LAST = WW'(EVAL_LAT - 1);
    localparam logic [WW-1:0] c_WAIT_ONE  = WW'(1);
    localparam logic [N:0]    c_CNT_ONE   = (N+1)'(1);
    localparam logic [N-1:0]  c_IDX_ONE   = N'(1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRV_A  = 3'd1,
        S_WAIT_A = 3'd2,
        S_DRV_B  = 3'd3,
        S_WAIT_B = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    state_t        state_q;
    logic [N-1:0]  idx_q;
    logic [N-1:0]  alpha_q;
    logic [N-1:0]  x_q;
    logic [WW-1:0] wait_q;
    logic          ya_q;
    logic          armed_q;
    logic          busy_q;
    logic          done_q;
    logic          sym_q;
    logic [N:0]    mis_q;
    logic [N:0]    on_q;

    // armed_q masks start on the first edge after reset release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            alpha_q <= '0;
            x_q     <= '0;
            wait_q  <= '0;
            ya_q    <= 1'b0;
            armed_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sym_q   <= 1'b0;
            mis_q   <= '0;
            on_q    <= '0;
        end else begin
            armed_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start && armed_q) begin
                        alpha_q <= alpha;
                        idx_q   <= '0;
                        mis_q   <= '0;
                        on_q    <= '0;
                        sym_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        wait_q  <= '0;
                        state_q <= S_DRV_A;
                    end
                end
                S_DRV_A: begin
                    x_q     <= idx_q;
                    wait_q  <= '0;
                    state_q <= S_WAIT_A;
                end
                S_WAIT_A: begin
                    if (wait_q == c_WAIT_LAST) begin
                        ya_q    <= y_in;
                        on_q    <= on_q + {{N{1'b0}}, y_in};
                        state_q <= S_DRV_B;
                    end else begin
                        wait_q <= wait_q + c_WAIT_ONE;
                    end
                end
                S_DRV_B: begin
                    x_q     <= idx_q ^ alpha_q;
                    wait_q  <= '0;
                    state_q <= S_WAIT_B;
                end
                S_WAIT_B: begin
                    if (wait_q == c_WAIT_LAST) begin
`ifdef AUTOSYM_EARLY_ABORT_EN
                        if (y_in != ya_q) begin
                            mis_q   <= mis_q + c_CNT_ONE;
                            state_q <= S_FIN;
                        end else if (&idx_q) begin
                            state_q <= S_FIN;
                        end else begin
                            idx_q   <= idx_q + c_IDX_ONE;
                            state_q <= S_DRV_A;
                        end
`else
                        if (y_in != ya_q) begin
                            mis_q <= mis_q + c_CNT_ONE;
                        end
                        if (&idx_q) begin
                            state_q <= S_FIN;
                        end else begin
                            idx_q   <= idx_q + c_IDX_ONE;
                            state_q <= S_DRV_A;
                        end
`endif
                    end else begin
                        wait_q <= wait_q + c_WAIT_ONE;
                    end
                end
                S_FIN: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    sym_q   <= (mis_q == '0);
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign x_out        = x_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign is_sym       = sym_q;
    assign mismatch_cnt = mis_q;
    assign onset_cnt    = on_q;

endmodule
`default_nettype wire

// File: tb/tb_autosym_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_autosym_sweep_ctrl
// Description : Directed self-checking bench for autosym_sweep_ctrl (N=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_autosym_sweep_ctrl;

    localparam int N = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [N-1:0] alpha;
    logic [N-1:0] x_out;
    logic         y_in;
    logic         busy;
    logic         done;
    logic         is_sym;
    logic [N:0]   mismatch_cnt;
    logic [N:0]   onset_cnt;

    int n_checks;
    int n_fail;
    int model;      // 0: y=0, 1: y=x0^x1, 2: y=x0&x1

    autosym_sweep_ctrl #(.N(N), .EVAL_LAT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .alpha        (alpha),
        .x_out        (x_out),
        .y_in         (y_in),
        .busy         (busy),
        .done         (done),
        .is_sym       (is_sym),
        .mismatch_cnt (mismatch_cnt),
        .onset_cnt    (onset_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        y_in = 1'b0;
        case (model)
            1:       y_in = x_out[0] ^ x_out[1];
            2:       y_in = x_out[0] & x_out[1];
            default: y_in = 1'b0;
        endcase
    end

    // Starts a sweep and counts edges after the accepting edge until done.
    // If pulse_at > 0, a second start with alpha=0xFF is pulsed at that cycle.
    task automatic run_sweep(input logic [N-1:0] a, input int pulse_at,
                             output int done_cyc, output bit busy_ok,
                             output bit sym_cleared);
        @(negedge clk);
        alpha = a;
        start = 1'b1;
        @(posedge clk);
        #1;
        busy_ok     = busy;
        sym_cleared = !is_sym;
        done_cyc    = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            start = (c == pulse_at);
            alpha = (c == pulse_at) ? 8'hFF : a;
            @(posedge clk);
            #1;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
        @(negedge clk);
        start = 1'b0;
        alpha = a;
    endtask

    task automatic test_reset;
        n_checks++; if (x_out !== 8'h00) begin n_fail++; $display("FAIL reset_x_out: got %h want 00", x_out); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (is_sym !== 1'b0) begin n_fail++; $display("FAIL reset_is_sym: got %b want 0", is_sym); end
        n_checks++; if (mismatch_cnt !== 9'd0) begin n_fail++; $display("FAIL reset_mismatch: got %0d want 0", mismatch_cnt); end
        n_checks++; if (onset_cnt !== 9'd0) begin n_fail++; $display("FAIL reset_onset: got %0d want 0", onset_cnt); end
    endtask

    task automatic test_xor_sym;
        int dc; bit bo; bit sc;
        model = 1;
        run_sweep(8'h03, 0, dc, bo, sc);
        n_checks++; if (dc !== 1025) begin n_fail++; $display("FAIL xor03_done_cycle: got %0d want 1025", dc); end
        n_checks++; if (bo !== 1'b1) begin n_fail++; $display("FAIL xor03_busy: got %b want 1", bo); end
        n_checks++; if (is_sym !== 1'b1) begin n_fail++; $display("FAIL xor03_is_sym: got %b want 1", is_sym); end
        n_checks++; if (mismatch_cnt !== 9'd0) begin n_fail++; $display("FAIL xor03_mismatch: got %0d want 0", mismatch_cnt); end
        n_checks++; if (onset_cnt !== 9'd128) begin n_fail++; $display("FAIL xor03_onset: got %0d want 128", onset_cnt); end
    endtask

    task automatic test_xor_nonsym;
        int dc; bit bo; bit sc;
        model = 1;
        run_sweep(8'h01, 0, dc, bo, sc);
        n_checks++; if (sc !== 1'b1) begin n_fail++; $display("FAIL xor01_sym_cleared_on_start: got %b want 1", sc); end
        n_checks++; if (is_sym !== 1'b0) begin n_fail++; $display("FAIL xor01_is_sym: got %b want 0", is_sym); end
`ifdef AUTOSYM_EARLY_ABORT_EN
        n_checks++; if (dc !== 5) begin n_fail++; $display("FAIL xor01_done_cycle: got %0d want 5", dc); end
        n_checks++; if (mismatch_cnt !== 9'd1) begin n_fail++; $display("FAIL xor01_mismatch: got %0d want 1", mismatch_cnt); end
`else
        n_checks++; if (dc !== 1025) begin n_fail++; $display("FAIL xor01_done_cycle: got %0d want 1025", dc); end
        n_checks++; if (mismatch_cnt !== 9'd256) begin n_fail++; $display("FAIL xor01_mismatch: got %0d want 256", mismatch_cnt); end
        n_checks++; if (onset_cnt !== 9'd128) begin n_fail++; $display("FAIL xor01_onset: got %0d want 128", onset_cnt); end
`endif
    endtask

    task automatic test_and;
        int dc; bit bo; bit sc;
        model = 2;
        run_sweep(8'h04, 0, dc, bo, sc);
        n_checks++; if (is_sym !== 1'b1) begin n_fail++; $display("FAIL and04_is_sym: got %b want 1", is_sym); end
        n_checks++; if (mismatch_cnt !== 9'd0) begin n_fail++; $display("FAIL and04_mismatch: got %0d want 0", mismatch_cnt); end
        n_checks++; if (onset_cnt !== 9'd64) begin n_fail++; $display("FAIL and04_onset: got %0d want 64", onset_cnt); end
        run_sweep(8'h01, 0, dc, bo, sc);
        n_checks++; if (is_sym !== 1'b0) begin n_fail++; $display("FAIL and01_is_sym: got %b want 0", is_sym); end
`ifndef AUTOSYM_EARLY_ABORT_EN
        n_checks++; if (mismatch_cnt !== 9'd128) begin n_fail++; $display("FAIL and01_mismatch: got %0d want 128", mismatch_cnt); end
`endif
    endtask

    task automatic test_back_to_back;
        int dc; bit bo; bit sc;
        model = 0;
        run_sweep(8'h00, 300, dc, bo, sc);
        n_checks++; if (dc !== 1025) begin n_fail++; $display("FAIL zero_done_cycle: got %0d want 1025", dc); end
        n_checks++; if (bo !== 1'b1) begin n_fail++; $display("FAIL zero_busy: got %b want 1", bo); end
        n_checks++; if (is_sym !== 1'b1) begin n_fail++; $display("FAIL zero_is_sym: got %b want 1", is_sym); end
        n_checks++; if (mismatch_cnt !== 9'd0) begin n_fail++; $display("FAIL zero_mismatch: got %0d want 0", mismatch_cnt); end
        n_checks++; if (onset_cnt !== 9'd0) begin n_fail++; $display("FAIL zero_onset: got %0d want 0", onset_cnt); end
        @(posedge clk); #1;
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL zero_done_one_cycle: got %b want 0", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_busy_after_done: got %b want 0", busy); end
    endtask

    task automatic test_reset_midsweep;
        int dc; bit bo; bit sc; bit saw_done;
        model = 1;
        @(negedge clk);
        alpha = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (499) @(negedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before_rst: got %b want 1", busy); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        n_checks++; if (x_out !== 8'h00) begin n_fail++; $display("FAIL mid_rst_x_out: got %h want 00", x_out); end
        n_checks++; if (mismatch_cnt !== 9'd0 || onset_cnt !== 9'd0) begin
            n_fail++; $display("FAIL mid_rst_counts: got %0d/%0d want 0/0", mismatch_cnt, onset_cnt); end
        n_checks++; if (is_sym !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_flags: got sym=%b done=%b want 0/0", is_sym, done); end
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1'b1;
        end
        n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL mid_no_done_after_rst: got %b want 0", saw_done); end
        run_sweep(8'h03, 0, dc, bo, sc);
        n_checks++; if (dc !== 1025) begin n_fail++; $display("FAIL mid_restart_done_cycle: got %0d want 1025", dc); end
        n_checks++; if (is_sym !== 1'b1 || mismatch_cnt !== 9'd0 || onset_cnt !== 9'd128) begin
            n_fail++; $display("FAIL mid_restart_result: got sym=%b mis=%0d on=%0d want 1/0/128", is_sym, mismatch_cnt, onset_cnt); end
    endtask

    task automatic test_start_at_reset_release;
        bit saw_done;
        model = 0;
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        alpha = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL release_start_ignored: got busy=%b want 0", busy); end
        @(posedge clk); #1;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL release_start_next_edge: got busy=%b want 1", busy); end
        @(negedge clk);
        start = 1'b0;
        saw_done = 1'b0;
        for (int c = 0; c < 1100; c++) begin
            @(posedge clk); #1;
            if (done) begin saw_done = 1'b1; break; end
        end
        n_checks++; if (saw_done !== 1'b1 || is_sym !== 1'b1) begin
            n_fail++; $display("FAIL release_sweep_done: got done=%b sym=%b want 1/1", saw_done, is_sym); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model    = 0;
        rst      = 1'b1;
        start    = 1'b0;
        alpha    = '0;
        repeat (3) @(negedge clk);
        test_reset;
        rst = 1'b0;
        @(negedge clk);
        test_xor_sym;
        test_xor_nonsym;
        test_and;
        test_back_to_back;
        test_reset_midsweep;
        test_start_at_reset_release;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/autosym_sweep_ctrl.md
Name: autosym_sweep_ctrl

Overview:
- Sequencer that checks whether a candidate vector alpha is an autosymmetry of a single-output combinational benchmark function, i.e. whether f(x) = f(x XOR alpha) holds for every x.
- One instance of the function is shared between the two operands of each comparison. The controller time-multiplexes x and x XOR alpha onto the function inputs and samples the output after each.
- Sits beside a synthesized netlist in the experiment harness: it drives the netlist inputs x0..x(N-1) and reads y0.
- Also reports the on-set size of the function.

Parameters:
- N, 8, number of function inputs; the sweep covers all 2^N vectors.
- EVAL_LAT, 1, cycles from an x_out update to a valid y_in sample; minimum 1.

Ports:
- clk  input  1  clock; all state is updated on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin a sweep; accepted only in IDLE.
- alpha  input  N  candidate symmetry vector; latched when start is accepted.
- x_out  output  N  registered function input vector.
- y_in  input  1  function output; sampled EVAL_LAT cycles after each x_out update.
- busy  output  1  high from start acceptance until the cycle done pulses.
- done  output  1  one-cycle pulse at the end of a sweep.
- is_sym  output  1  1 if there were no mismatches; valid from done, held until the next accepted start.
- mismatch_cnt  output  N+1  number of x for which f(x) != f(x XOR alpha); range 0..2^N.
- onset_cnt  output  N+1  number of x with f(x) = 1; range 0..2^N.

Behaviour:
- Reset values: x_out=0, busy=0, done=0, is_sym=0, mismatch_cnt=0, onset_cnt=0. Internal idx=0, alpha_q=0, FSM in IDLE.
- FSM states: IDLE, DRV_A, WAIT_A, DRV_B, WAIT_B, FIN.
- IDLE:
  - On start=1: latch alpha_q=alpha, set idx=0, clear both counters, set is_sym=0, set busy=1, go to DRV_A.
- DRV_A: x_out <= idx. Go to WAIT_A.
- WAIT_A:
  - Stay EVAL_LAT cycles.
  - On the last cycle, capture ya=y_in and add ya to onset_cnt.
  - Go to DRV_B.
- DRV_B: x_out <= idx XOR alpha_q. Go to WAIT_B.
- WAIT_B:
  - Stay EVAL_LAT cycles.
  - On the last cycle, if y_in != ya, increment mismatch_cnt.
  - If idx = 2^N-1, go to FIN. Otherwise idx <= idx+1 (N-bit counter) and go to DRV_A.
- FIN:
  - Assert done for one cycle and set is_sym=(mismatch_cnt==0).
  - busy drops in the same cycle. Return to IDLE.
- Latency: each vector takes 2*(EVAL_LAT+1) cycles. done is high exactly 2*(EVAL_LAT+1)*2^N + 1 cycles after the edge that accepted start; this is 1025 cycles for the defaults.
- x_out holds its last value in IDLE and FIN.
- start while busy: ignored. alpha is not re-latched.
- alpha changing mid-sweep: no effect, because alpha_q is used.
- alpha=0: every pair matches, so is_sym=1 and mismatch_cnt=0.
- Counter width: N+1 bits. The terminal value 2^N is representable and never wraps.
- Each unordered pair {x, x XOR alpha} is visited twice. For alpha != 0, mismatch_cnt is therefore always even.
- rst asserted mid-sweep: immediate return to the reset values. No done pulse. Results of the partial sweep are discarded.
- start high in the same cycle rst deasserts: ignored in that cycle, accepted from the next edge on.

Optional Feature:
- Macro: AUTOSYM_EARLY_ABORT_EN.
- Defined:
  - On the first mismatch in WAIT_B, go directly to FIN, with mismatch_cnt=1 and is_sym=0.
  - onset_cnt then holds only the partial count and is not meaningful; the bench must not check it.
- Undefined: every sweep covers all 2^N vectors, as described in Behaviour.

Test Plan:
- Model y=x0^x1, alpha=0x03 -> done at cycle 1025, is_sym=1, mismatch_cnt=0, onset_cnt=128.
- Same model, alpha=0x01 -> is_sym=0, mismatch_cnt=256, onset_cnt=128.
- Model y=x0&x1:
  - alpha=0x04 -> is_sym=1, onset_cnt=64.
  - alpha=0x01 -> is_sym=0, mismatch_cnt=128.
- Model y=0, alpha=0x00 -> is_sym=1, both counters 0. A second start pulsed at cycle 300 is ignored, and done still arrives at cycle 1025.
- rst pulsed at cycle 500 of a sweep -> all outputs 0 immediately and no done. A fresh start then completes with the correct result.
- With AUTOSYM_EARLY_ABORT_EN, y=x0^x1, alpha=0x01 -> mismatch found at idx=0 and done at cycle 5, with mismatch_cnt=1 and is_sym=0.
